// File: rtl/regfile_port_sched_if.sv
// Bundle of the operand-read, two writeback and register-file pin groups
// that the port scheduler arbitrates between.
interface regfile_port_sched_if #(
  parameter int DATA_W = 8
);
  logic              rd_valid;
  logic [1:0]        rd_ra;
  logic [1:0]        rd_rb;
  logic              rd_ready;
  logic              rd_done;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  logic              wb0_valid;
  logic [1:0]        wb0_reg;
  logic [DATA_W-1:0] wb0_data;
  logic              wb0_ready;

  logic              wb1_valid;
  logic [1:0]        wb1_reg;
  logic [DATA_W-1:0] wb1_data;
  logic              wb1_ready;

  logic              rf_load1;
  logic              rf_load2;
  logic [1:0]        rf_r1;
  logic [1:0]        rf_r2;
  logic [DATA_W-1:0] rf_in1;
  logic [DATA_W-1:0] rf_in2;
  logic [DATA_W-1:0] rf_out1;
  logic [DATA_W-1:0] rf_out2;

  modport slave (
    input  rd_valid, rd_ra, rd_rb,
    input  wb0_valid, wb0_reg, wb0_data,
    input  wb1_valid, wb1_reg, wb1_data,
    input  rf_out1, rf_out2,
    output rd_ready, rd_done, rd_a, rd_b,
    output wb0_ready, wb1_ready,
    output rf_load1, rf_load2, rf_r1, rf_r2, rf_in1, rf_in2
  );

  modport master (
    output rd_valid, rd_ra, rd_rb,
    output wb0_valid, wb0_reg, wb0_data,
    output wb1_valid, wb1_reg, wb1_data,
    output rf_out1, rf_out2,
    input  rd_ready, rd_done, rd_a, rd_b,
    input  wb0_ready, wb1_ready,
    input  rf_load1, rf_load2, rf_r1, rf_r2, rf_in1, rf_in2
  );
endinterface

// File: rtl/regfile_port_sched.sv
// Shares the two address-shared register-file ports between one operand
// reader and two writeback sources, per cycle either reading or writing.
module regfile_port_sched #(
  parameter int WR_STREAK_MAX = 3,
  parameter int DATA_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  regfile_port_sched_if.slave bus
);

  typedef enum logic [1:0] {
    CYC_IDLE  = 2'd0,
    CYC_READ  = 2'd1,
    CYC_WRITE = 2'd2
  } cyc_t;

  localparam logic [3:0] STREAK_MAX = 4'(WR_STREAK_MAX);

  cyc_t              cyc;
  logic              hazard;
  logic              conflict;
  logic              any_wb;

  logic [3:0]        streak_p0;
  logic              rr_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] rd_a_p1;
  logic [DATA_W-1:0] rd_b_p1;

  function automatic logic src_match(input logic [1:0] ra,
                                     input logic [1:0] rb,
                                     input logic [1:0] wr);
    return (ra == wr) || (rb == wr);
  endfunction

  always_comb begin
    any_wb   = bus.wb0_valid || bus.wb1_valid;
    conflict = bus.wb0_valid && bus.wb1_valid && (bus.wb0_reg == bus.wb1_reg);
    hazard   = bus.rd_valid &&
               ((bus.wb0_valid && src_match(bus.rd_ra, bus.rd_rb, bus.wb0_reg)) ||
                (bus.wb1_valid && src_match(bus.rd_ra, bus.rd_rb, bus.wb1_reg)));

    // A waiting read wins outright when nobody writes, or once the write
    // streak is exhausted and none of its sources is still being written.
    cyc = CYC_IDLE;
    if (rst) begin
      cyc = CYC_IDLE;
    end else if (bus.rd_valid &&
                 (!any_wb || ((streak_p0 == STREAK_MAX) && !hazard))) begin
      cyc = CYC_READ;
    end else if (any_wb) begin
      cyc = CYC_WRITE;
    end
  end

  always_comb begin
    bus.rd_ready  = 1'b0;
    bus.wb0_ready = 1'b0;
    bus.wb1_ready = 1'b0;
    bus.rf_load1  = 1'b0;
    bus.rf_load2  = 1'b0;
    bus.rf_r1     = 2'd0;
    bus.rf_r2     = 2'd0;
    bus.rf_in1    = '0;
    bus.rf_in2    = '0;

    case (cyc)
      CYC_READ: begin
        bus.rd_ready = 1'b1;
        bus.rf_r1    = bus.rd_ra;
        bus.rf_r2    = bus.rd_rb;
      end
      CYC_WRITE: begin
        if (bus.wb0_valid && bus.wb1_valid && !conflict) begin
          bus.wb0_ready = 1'b1;
          bus.wb1_ready = 1'b1;
          bus.rf_load1  = 1'b1;
          bus.rf_r1     = bus.wb0_reg;
          bus.rf_in1    = bus.wb0_data;
          bus.rf_load2  = 1'b1;
          bus.rf_r2     = bus.wb1_reg;
          bus.rf_in2    = bus.wb1_data;
        end else if ((conflict && rr_p0) || (!conflict && !bus.wb0_valid)) begin
          // Only wb1 goes: either it is the favoured side of a same-register
          // collision, or it is the lone requester.
          bus.wb1_ready = 1'b1;
          bus.rf_load1  = 1'b1;
          bus.rf_r1     = bus.wb1_reg;
          bus.rf_in1    = bus.wb1_data;
        end else begin
          bus.wb0_ready = 1'b1;
          bus.rf_load1  = 1'b1;
          bus.rf_r1     = bus.wb0_reg;
          bus.rf_in1    = bus.wb0_data;
        end
      end
      default: begin
      end
    endcase
  end

  // Stage p0 -> p1: streak/round-robin bookkeeping and operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_p0 <= 4'd0;
      rr_p0     <= 1'b0;
      vld_p1    <= 1'b0;
      rd_a_p1   <= '0;
      rd_b_p1   <= '0;
    end else begin
      vld_p1 <= (cyc == CYC_READ);
      if (cyc == CYC_READ) begin
        rd_a_p1 <= bus.rf_out1;
        rd_b_p1 <= bus.rf_out2;
      end
      if ((cyc == CYC_WRITE) && conflict) begin
        rr_p0 <= ~rr_p0;
      end
      if (!bus.rd_valid || (cyc == CYC_READ)) begin
        streak_p0 <= 4'd0;
      end else if ((cyc == CYC_WRITE) && (streak_p0 != STREAK_MAX)) begin
        streak_p0 <= streak_p0 + 4'd1;
      end
    end
  end

  assign bus.rd_done = vld_p1;
  assign bus.rd_a    = rd_a_p1;
  assign bus.rd_b    = rd_b_p1;

endmodule

// File: tb/tb_regfile_port_sched.sv
// Directed bench for regfile_port_sched with a behavioural 4x8 register file
// wired to the scheduler's rf_* pins.
module tb_regfile_port_sched;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_port_sched_if bus ();

  regfile_port_sched #(.WR_STREAK_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [4];

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) mem[k] <= 8'h00;
    end else begin
      if (bus.rf_load1) mem[bus.rf_r1] <= bus.rf_in1;
      if (bus.rf_load2) mem[bus.rf_r2] <= bus.rf_in2;
    end
  end

  assign bus.rf_out1 = mem[bus.rf_r1];
  assign bus.rf_out2 = mem[bus.rf_r2];

  int total = 0;
  int bad   = 0;

  logic [1:0] ro_ra [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] ro_rb [4] = '{2'd2, 2'd1, 2'd0, 2'd3};
  logic [7:0] ro_ea [4] = '{8'h65, 8'h22, 8'hB0, 8'h00};
  logic [7:0] ro_eb [4] = '{8'h22, 8'h65, 8'h00, 8'hB0};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rd(input logic v, input logic [1:0] a, input logic [1:0] b);
    bus.rd_valid = v;
    bus.rd_ra    = a;
    bus.rd_rb    = b;
  endtask

  task automatic set_wb0(input logic v, input logic [1:0] r, input logic [7:0] d);
    bus.wb0_valid = v;
    bus.wb0_reg   = r;
    bus.wb0_data  = d;
  endtask

  task automatic set_wb1(input logic v, input logic [1:0] r, input logic [7:0] d);
    bus.wb1_valid = v;
    bus.wb1_reg   = r;
    bus.wb1_data  = d;
  endtask

  initial begin
    // Reset held two cycles with every requester asserting.
    rst = 1'b1;
    set_rd(1'b1, 2'd1, 2'd2);
    set_wb0(1'b1, 2'd1, 8'h5A);
    set_wb1(1'b1, 2'd2, 8'hA5);
    settle();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_rd_ready", bus.rd_ready, 1'b0);
      chk("rst_wb0_ready", bus.wb0_ready, 1'b0);
      chk("rst_wb1_ready", bus.wb1_ready, 1'b0);
      chk("rst_load1", bus.rf_load1, 1'b0);
      chk("rst_load2", bus.rf_load2, 1'b0);
    end
    rst = 1'b0;
    set_rd(1'b0, 2'd0, 2'd0);
    set_wb0(1'b0, 2'd0, 8'h00);
    set_wb1(1'b0, 2'd0, 8'h00);
    settle();
    chk("post_rst_rd_done", bus.rd_done, 1'b0);
    chk("post_rst_rd_a", bus.rd_a, 8'h00);
    chk("post_rst_rd_b", bus.rd_b, 8'h00);
    chk("idle_rd_ready", bus.rd_ready, 1'b0);

    // Same-destination conflict: rr starts on wb0, then favours wb1.
    set_wb0(1'b1, 2'd3, 8'hA0);
    set_wb1(1'b1, 2'd3, 8'hB0);
    settle();
    chk("cf1_wb0_ready", bus.wb0_ready, 1'b1);
    chk("cf1_wb1_ready", bus.wb1_ready, 1'b0);
    chk("cf1_r1", {6'd0, bus.rf_r1}, 8'd3);
    chk("cf1_in1", bus.rf_in1, 8'hA0);
    chk("cf1_load2", bus.rf_load2, 1'b0);
    tick();
    settle();
    chk("cf2_wb0_ready", bus.wb0_ready, 1'b0);
    chk("cf2_wb1_ready", bus.wb1_ready, 1'b1);
    chk("cf2_in1", bus.rf_in1, 8'hB0);
    chk("cf2_load2", bus.rf_load2, 1'b0);
    tick();
    set_wb0(1'b0, 2'd0, 8'h00);
    set_wb1(1'b0, 2'd0, 8'h00);
    set_rd(1'b1, 2'd3, 2'd3);
    settle();
    chk("cf_rd_ready", bus.rd_ready, 1'b1);
    tick();

    // Dual write to distinct registers, then read them back.
    set_rd(1'b0, 2'd0, 2'd0);
    set_wb0(1'b1, 2'd1, 8'h11);
    set_wb1(1'b1, 2'd2, 8'h22);
    settle();
    chk("cf_rd_done", bus.rd_done, 1'b1);
    chk("cf_rd_a", bus.rd_a, 8'hB0);
    chk("cf_rd_b", bus.rd_b, 8'hB0);
    chk("dw_wb0_ready", bus.wb0_ready, 1'b1);
    chk("dw_wb1_ready", bus.wb1_ready, 1'b1);
    chk("dw_r1", {6'd0, bus.rf_r1}, 8'd1);
    chk("dw_in1", bus.rf_in1, 8'h11);
    chk("dw_r2", {6'd0, bus.rf_r2}, 8'd2);
    chk("dw_in2", bus.rf_in2, 8'h22);
    chk("dw_load2", bus.rf_load2, 1'b1);
    tick();
    set_wb0(1'b0, 2'd0, 8'h00);
    set_wb1(1'b0, 2'd0, 8'h00);
    set_rd(1'b1, 2'd1, 2'd2);
    settle();
    chk("dw_rd_done_low", bus.rd_done, 1'b0);
    chk("dw_rd_ready", bus.rd_ready, 1'b1);
    tick();
    set_rd(1'b0, 2'd0, 2'd0);
    settle();
    chk("dw_rd_done", bus.rd_done, 1'b1);
    chk("dw_rd_a", bus.rd_a, 8'h11);
    chk("dw_rd_b", bus.rd_b, 8'h22);
    tick();
    settle();
    chk("hold_rd_done", bus.rd_done, 1'b0);
    chk("hold_rd_a", bus.rd_a, 8'h11);

    // Starvation: three writes, a forced read, then writes resume.
    set_rd(1'b1, 2'd0, 2'd0);
    set_wb0(1'b1, 2'd1, 8'h55);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("sv%0d_rd_ready", i), bus.rd_ready, (i == 3));
      chk($sformatf("sv%0d_wb0_ready", i), bus.wb0_ready, (i != 3));
      chk($sformatf("sv%0d_load1", i), bus.rf_load1, (i != 3));
      if (i == 4) begin
        chk("sv_rd_done", bus.rd_done, 1'b1);
        chk("sv_rd_a", bus.rd_a, 8'h00);
      end
      tick();
    end
    set_rd(1'b0, 2'd0, 2'd0);
    set_wb0(1'b0, 2'd0, 8'h00);
    tick();

    // Hazard holds off the forced read until the write target moves away.
    set_rd(1'b1, 2'd1, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      set_wb0(1'b1, 2'd1, 8'(8'h60 + i));
      settle();
      chk($sformatf("hz%0d_rd_ready", i), bus.rd_ready, 1'b0);
      chk($sformatf("hz%0d_wb0_ready", i), bus.wb0_ready, 1'b1);
      tick();
    end
    set_wb0(1'b1, 2'd2, 8'h77);
    settle();
    chk("hz_forced_rd_ready", bus.rd_ready, 1'b1);
    chk("hz_forced_wb0_ready", bus.wb0_ready, 1'b0);
    tick();
    set_rd(1'b0, 2'd0, 2'd0);
    set_wb0(1'b0, 2'd0, 8'h00);
    settle();
    chk("hz_rd_done", bus.rd_done, 1'b1);
    chk("hz_rd_a", bus.rd_a, 8'h65);
    chk("hz_rd_b", bus.rd_b, 8'h00);
    tick();

    // Read-only traffic: a grant every cycle, rd_done continuous.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_rd(1'b1, ro_ra[i], ro_rb[i]);
      else       set_rd(1'b0, 2'd0, 2'd0);
      settle();
      chk($sformatf("ro%0d_rd_ready", i), bus.rd_ready, (i < 4));
      chk($sformatf("ro%0d_rd_done", i), bus.rd_done, (i > 0));
      if (i > 0) begin
        chk($sformatf("ro%0d_rd_a", i), bus.rd_a, ro_ea[i-1]);
        chk($sformatf("ro%0d_rd_b", i), bus.rd_b, ro_eb[i-1]);
      end
      tick();
    end

    // Reset right after a read grant swallows its rd_done.
    set_rd(1'b1, 2'd3, 2'd3);
    settle();
    chk("mr_rd_ready", bus.rd_ready, 1'b1);
    tick();
    rst = 1'b1;
    set_wb0(1'b1, 2'd1, 8'h99);
    settle();
    chk("mr_rst_rd_ready", bus.rd_ready, 1'b0);
    chk("mr_rst_wb0_ready", bus.wb0_ready, 1'b0);
    chk("mr_rst_load1", bus.rf_load1, 1'b0);
    tick();
    rst = 1'b0;
    set_rd(1'b0, 2'd0, 2'd0);
    set_wb0(1'b0, 2'd0, 8'h00);
    settle();
    chk("mr_rd_done", bus.rd_done, 1'b0);
    chk("mr_rd_a", bus.rd_a, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_port_sched.md
# regfile_port_sched

Scheduler that shares the two address-shared ports of the 4×8-bit register file between one operand-read requester (decode) and two writeback requesters (wb0 = ALU, wb1 = memory). Each cycle is either a write cycle (up to two writes) or a read cycle (both ports read). The block guarantees three things: no two writes ever target the same register in one cycle; reads never bypass a pending write to a register they source; and reads are not starved. It sits between the pipeline stages and the register file and drives all register-file control pins.

## Interface
Parameters:
- WR_STREAK_MAX, default 3: number of consecutive write cycles allowed while a read waits, before a read cycle is forced (range 1..15).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- rd_valid  in  1  operand read request
- rd_ra, rd_rb  in  2 each  source registers
- rd_ready  out  1  read granted this cycle
- rd_done  out  1  pulses one cycle after a read grant
- rd_a, rd_b  out  8 each  registered operand data, valid when rd_done=1
- wb0_valid / wb1_valid  in  1  write requests
- wb0_reg / wb1_reg  in  2  destination registers
- wb0_data / wb1_data  in  8  write data
- wb0_ready / wb1_ready  out  1  write granted this cycle
- rf_load1, rf_load2  out  1  register-file write enables
- rf_r1, rf_r2  out  2  register-file port addresses, shared by read and write
- rf_in1, rf_in2  out  8  register-file write data
- rf_out1, rf_out2  in  8  register-file read data, combinational from rf_r1/rf_r2

## Operation
- **State:** streak counter (4 bits), round-robin pointer rr (0 = wb0 favoured, 1 = wb1 favoured), rd_done flag, and rd_a/rd_b registers.
- **Handshakes:** a transfer occurs when valid and ready are both 1. Requesters must hold valid, reg and data stable until the transfer. Ready depends only on the valids, regs and state; it never depends on the other ready outputs.
- **Hazard:** the hazard signal is 1 when rd_valid=1 and rd_ra or rd_rb equals the reg of any wb with valid=1.
- **Cycle type:**
  - Read cycle if rd_valid=1 and no wb is valid.
  - Read cycle if rd_valid=1, streak==WR_STREAK_MAX and there is no hazard.
  - Otherwise it is a write cycle if any wb is valid.
  - Otherwise the cycle is idle.
- **Read cycle:**
  - rd_ready=1; both wb_ready=0.
  - rf_r1=rd_ra, rf_r2=rd_rb, rf_load1=rf_load2=0.
  - At the clock edge, rd_a←rf_out1 and rd_b←rf_out2, and rd_done←1.
- **Write cycle:**
  - rd_ready=0.
  - Both wb valid with different regs: grant both. wb0 drives port 1 (rf_r1/rf_in1/rf_load1) and wb1 drives port 2.
  - Both wb valid with the same reg: grant only the one selected by rr, on port 1. rf_load2=0. rr toggles at the edge.
  - One wb valid: grant it on port 1. rf_load2=0.
- **Idle cycle:** all ready outputs are 0.
- **Unused port:** load=0, r=0, in=0.
- **rr update:** rr changes only on a same-reg conflict.
- **Streak counter:**
  - Increments (saturating at WR_STREAK_MAX) on a write cycle while rd_valid=1.
  - Clears to 0 on a read cycle or whenever rd_valid=0.
  - If a hazard blocks the forced read, writes proceed and streak holds at WR_STREAK_MAX. The read is granted on the first cycle with no hazard.
- **rd_done:** cleared in any cycle that is not a read cycle. rd_a and rd_b hold their value until the next read.

## Timing
- **Reset values:** streak=0, rr=0, rd_done=0, rd_a=rd_b=0.
- **Combinational outputs:** all rf_* and *_ready outputs are combinational. rd_done, rd_a and rd_b are registered.
- **Write latency:** a write granted in cycle N is in the register file after edge N. A read granted in cycle N+1 or later sees the new value.
- **Read latency:** read grant in cycle N gives rd_done=1 and valid rd_a/rd_b in cycle N+1, i.e. one cycle.
- **Back-to-back reads:** reads may be granted every cycle. rd_done stays high continuously.
- **Reset mid-operation:** rst has priority over everything.
  - While rst=1: all ready outputs are 0 and rf_load1=rf_load2=0.
  - A read granted in the cycle before reset yields no rd_done after reset.
- **Throughput:**
  - Maximum 2 writes per cycle.
  - At least 1 read per WR_STREAK_MAX+1 cycles while rd_valid is held and there is no hazard.

## Test plan
- **Reset:** hold rst=1 for 2 cycles with all valids=1 -> all ready=0, rf_load1=rf_load2=0. After release: rd_done=0 and rd_a=rd_b=0.
- **Dual write:** wb0 (reg 1, 0x11) and wb1 (reg 2, 0x22) together -> both ready=1, rf_r1=1, rf_in1=0x11, rf_r2=2, rf_in2=0x22. A read of (1,2) next cycle -> rd_a=0x11, rd_b=0x22 with rd_done one cycle after the grant.
- **Same-dest conflict:** wb0 and wb1 both target reg 3 for 2 cycles from reset:
  - Cycle 1: wb0 granted, wb1 blocked.
  - Cycle 2: wb1 granted.
  - Final reg 3 value is wb1_data.
  - rf_load2=0 throughout.
- **Starvation, WR_STREAK_MAX=3:** rd_valid (ra=0, rb=0) held; wb0 valid to reg 1 every cycle -> 3 write cycles, then rd_ready=1 in cycle 4, then streak restarts.
- **Hazard-blocked force:** same as the starvation case but rd_ra=1 -> no read grant while wb0 targets reg 1. Drop wb0_valid -> read is granted next cycle and returns the last written value.
- **Idle and read-only:** no wb valid, rd_valid=1 every cycle for 4 cycles -> rd_ready=1 each cycle; rd_done=1 in cycles 2–5 with the correct data.
